// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and field positions for the packet router core.
//   Flit layout (DATA_W >= 6): type in the two MSBs, destination port in the
//   next two bits down. Field offsets are expressed relative to DATA_W so the
//   same constants serve any flit width.
package router_pkg;

  localparam int NPORTS   = 4;
  localparam int TYPE_W   = 2;
  localparam int PORT_W   = 2;
  // Field LSB = DATA_W - *_OFS
  localparam int TYPE_OFS = 2;
  localparam int PORT_OFS = 4;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_PASS = 2'd2
  } state_e;

endpackage

// File: rtl/router_port_arbiter.sv
// router_port_arbiter
//   Per-port lock and registered grant for the router decoder.
//   Ports:
//     clk    clock
//     rst    synchronous active-high reset
//     rqst   decoder is holding a header and wants its port
//     port   port being requested / released
//     rel    release the lock on `port` (tail leaving the switch);
//            named rel because `release` is a reserved word
//     grant  registered: high one cycle after a request on a free port and
//            held for as long as the lock is owned
module router_port_arbiter
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rqst,
  input  logic [PORT_W-1:0] port,
  input  logic              rel,
  output logic              grant
);

  logic [NPORTS-1:0] lock;

  // A release takes priority over any request seen in the same cycle; the
  // requester is only granted on a following cycle once the lock is clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock  <= '0;
      grant <= 1'b0;
    end else if (rel) begin
      lock[port] <= 1'b0;
      grant      <= 1'b0;
    end else if (rqst && !lock[port]) begin
      lock[port] <= 1'b1;
      grant      <= 1'b1;
    end
  end

endmodule

// File: rtl/router_switch.sv
// router_switch
//   Routing core: one valid/ready flit input, four valid/ready outputs.
//   A header is held, its port is locked through router_port_arbiter, and
//   every flit up to and including the tail is forwarded to that port.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     lvalid/lrdy/ldata   input flit stream
//     rNvalid/rNrdy/rNdata  output N flit stream (N = 0..3)
//   Build option:
//     ROUTER_HDR_STRIP_EN  when defined, the header is consumed on grant and
//                          only body/tail flits are forwarded.
//
//   state  | meaning
//   -------+------------------------------------------------
//   S_IDLE | waiting for a header; other flits are dropped
//   S_REQ  | header held, requesting its port from the arbiter
//   S_PASS | packet owns its port; flits forwarded until tail
module router_switch
  import router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lvalid,
  output logic              lrdy,
  input  logic [DATA_W-1:0] ldata,
  output logic              r0valid,
  input  logic              r0rdy,
  output logic [DATA_W-1:0] r0data,
  output logic              r1valid,
  input  logic              r1rdy,
  output logic [DATA_W-1:0] r1data,
  output logic              r2valid,
  input  logic              r2rdy,
  output logic [DATA_W-1:0] r2data,
  output logic              r3valid,
  input  logic              r3rdy,
  output logic [DATA_W-1:0] r3data
);

  localparam int TLSB = DATA_W - TYPE_OFS;
  localparam int PLSB = DATA_W - PORT_OFS;

  state_e            state;
  logic              full;
  logic [DATA_W-1:0] flit;
  logic [PORT_W-1:0] port;

  logic              rqst, grant, rel;
  logic              out_valid, out_rdy, out_xfer, in_xfer;
  logic [NPORTS-1:0] rrdy_v;
  flit_type_e        in_type, held_type;

  assign in_type   = flit_type_e'(ldata[TLSB +: TYPE_W]);
  assign held_type = flit_type_e'(flit[TLSB +: TYPE_W]);

`ifdef ROUTER_HDR_STRIP_EN
  assign out_valid = full && (state == S_PASS);
`else
  // The header goes out in the grant cycle, before the FSM reaches S_PASS.
  assign out_valid = full && ((state == S_PASS) || ((state == S_REQ) && grant));
`endif

  assign rrdy_v   = {r3rdy, r2rdy, r1rdy, r0rdy};
  assign out_rdy  = rrdy_v[port];
  assign out_xfer = out_valid && out_rdy;
  assign lrdy     = !full || out_xfer;
  assign in_xfer  = lvalid && lrdy;

  assign rqst = (state == S_REQ);
  assign rel  = (state == S_PASS) && out_xfer && (held_type == FT_TAIL);

  router_port_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .rqst  (rqst),
    .port  (port),
    .rel   (rel),
    .grant (grant)
  );

  // Flits accepted in the same cycle as a state change are interpreted in
  // the state being entered: after the tail leaves, a new header can be
  // taken immediately; after the header leaves on grant, a body can follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      full  <= 1'b0;
      flit  <= '0;
      port  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer && (in_type == FT_HEAD)) begin
            full  <= 1'b1;
            flit  <= ldata;
            port  <= ldata[PLSB +: PORT_W];
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (grant) begin
            state <= S_PASS;
`ifdef ROUTER_HDR_STRIP_EN
            full  <= 1'b0;
`else
            if (out_xfer) full <= 1'b0;
            if (in_xfer && (in_type != FT_IDLE)) begin
              full <= 1'b1;
              flit <= ldata;
            end
`endif
          end
        end
        S_PASS: begin
          if (out_xfer) full <= 1'b0;
          if (rel) begin
            state <= S_IDLE;
            if (in_xfer && (in_type == FT_HEAD)) begin
              full  <= 1'b1;
              flit  <= ldata;
              port  <= ldata[PLSB +: PORT_W];
              state <= S_REQ;
            end
          end else if (in_xfer && (in_type != FT_IDLE)) begin
            // Headers inside a packet are carried along like body flits.
            full <= 1'b1;
            flit <= ldata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign r0valid = out_valid && (port == PORT_W'(0));
  assign r1valid = out_valid && (port == PORT_W'(1));
  assign r2valid = out_valid && (port == PORT_W'(2));
  assign r3valid = out_valid && (port == PORT_W'(3));

  assign r0data = r0valid ? flit : '0;
  assign r1data = r1valid ? flit : '0;
  assign r2data = r2valid ? flit : '0;
  assign r3data = r3valid ? flit : '0;

endmodule

// File: tb/tb_router_switch.sv
// tb_router_switch
//   Directed bench for router_switch with a scoreboard of expected
//   {port, flit} pairs. Honors ROUTER_HDR_STRIP_EN when defined.
module tb_router_switch;
  import router_pkg::*;

`ifdef ROUTER_HDR_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lvalid = 1'b0;
  logic       lrdy;
  logic [7:0] ldata = 8'h00;
  logic       r0valid, r1valid, r2valid, r3valid;
  logic       r0rdy = 1'b1, r1rdy = 1'b1, r2rdy = 1'b1, r3rdy = 1'b1;
  logic [7:0] r0data, r1data, r2data, r3data;

  int total  = 0;
  int passed = 0;
  logic [31:0] sb[$];

  router_switch #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .lvalid(lvalid), .lrdy(lrdy), .ldata(ldata),
    .r0valid(r0valid), .r0rdy(r0rdy), .r0data(r0data),
    .r1valid(r1valid), .r1rdy(r1rdy), .r1data(r1data),
    .r2valid(r2valid), .r2rdy(r2rdy), .r2data(r2data),
    .r3valid(r3valid), .r3rdy(r3rdy), .r3data(r3data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0]  vv, rr;
    logic [7:0]  dd [4];
    logic [31:0] e;
    vv = {r3valid, r2valid, r1valid, r0valid};
    rr = {r3rdy, r2rdy, r1rdy, r0rdy};
    dd[0] = r0data; dd[1] = r1data; dd[2] = r2data; dd[3] = r3data;
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (vv[p] && rr[p]) begin
          if (sb.size() > 0) e = sb.pop_front();
          else e = 32'hFFFF_FFFF;
          check("route", (32'(p) << 8) | 32'(dd[p]), e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit; returns one step after the edge that accepted it.
  task automatic send(input logic [7:0] d, input int port, input bit fwd);
    int n;
    n = 0;
    lvalid = 1'b1;
    ldata  = d;
    #1;
    while (!lrdy && n < 64) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("send_lrdy", 32'(lrdy), 32'd1);
    if (fwd && !(STRIP && d[7:6] == 2'b01))
      sb.push_back((32'(port) << 8) | 32'(d));
    @(posedge clk);
    #1;
    lvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_lrdy", 32'(lrdy), 32'd1);
    check("rst_valid", 32'({r3valid, r2valid, r1valid, r0valid}), 32'd0);
    check("rst_data", {r3data, r2data, r1data, r0data}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_lock", 32'(dut.u_arb.lock), 32'd0);

    // Packet to port 1, all outputs ready, header latency measured
    send(8'h55, 1, 1'b1);
    #1;
    check("hdr_c1_lrdy", 32'(lrdy), 32'd0);
    check("hdr_c1_r1valid", 32'(r1valid), 32'd0);
    tick();
    check("hdr_c2_r1valid", 32'(r1valid), STRIP ? 32'd0 : 32'd1);
    check("hdr_c2_r1data", 32'(r1data), STRIP ? 32'd0 : 32'h55);
    send(8'h96, 1, 1'b1);
    send(8'h97, 1, 1'b1);
    send(8'h98, 1, 1'b1);
    send(8'h99, 1, 1'b1);
    send(8'hDA, 1, 1'b1);
    drain("drain_a");
    check("lock1_free", 32'(dut.u_arb.lock[1]), 32'd0);
    check("state_a_idle", 32'(dut.state), 32'(S_IDLE));

    // Same packet with a one-cycle stall on r1 while 0x99 is held
    send(8'h55, 1, 1'b1);
    send(8'h96, 1, 1'b1);
    send(8'h97, 1, 1'b1);
    send(8'h98, 1, 1'b1);
    send(8'h99, 1, 1'b1);
    r1rdy = 1'b0;
    #1;
    check("bp_r1valid", 32'(r1valid), 32'd1);
    check("bp_r1data", 32'(r1data), 32'h99);
    check("bp_lrdy", 32'(lrdy), 32'd0);
    tick();
    check("bp_hold_valid", 32'(r1valid), 32'd1);
    check("bp_hold_data", 32'(r1data), 32'h99);
    r1rdy = 1'b1;
    send(8'hDA, 1, 1'b1);
    drain("drain_bp");

    // Packet to port 3
    send(8'h75, 3, 1'b1);
    send(8'hB6, 3, 1'b1);
    send(8'hB7, 3, 1'b1);
    send(8'hB8, 3, 1'b1);
    send(8'hB9, 3, 1'b1);
    send(8'hFA, 3, 1'b1);
    drain("drain_b");
    check("lock3_free", 32'(dut.u_arb.lock[3]), 32'd0);

    // Body with no header is dropped
    send(8'h96, 1, 1'b0);
    repeat (3) tick();
    check("orphan_valid", 32'({r3valid, r2valid, r1valid, r0valid}), 32'd0);
    check("orphan_state", 32'(dut.state), 32'(S_IDLE));
    check("orphan_full", 32'(dut.full), 32'd0);

    // Reset in the middle of a packet
    send(8'h55, 1, 1'b1);
    send(8'h96, 1, 1'b1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_lrdy", 32'(lrdy), 32'd1);
    check("mid_rst_valid", 32'({r3valid, r2valid, r1valid, r0valid}), 32'd0);
    check("mid_rst_data", {r3data, r2data, r1data, r0data}, 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(S_IDLE));
    check("mid_rst_lock", 32'(dut.u_arb.lock), 32'd0);
    send(8'h75, 3, 1'b1);
    send(8'hB6, 3, 1'b1);
    send(8'hFA, 3, 1'b1);
    drain("drain_post_rst");
    check("lock3_post_rst", 32'(dut.u_arb.lock[3]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
